lsd_line_buffer_mc: RTL and testbench
=====================================

Name: lsd_line_buffer_mc

Overview:
Multi-channel, double-buffered store for line segments from simple_lsd. One write port per camera channel (NUM_CH of them), one shared read port for the PS register bridge. Each channel collects one frame's segments into its write bank. At end-of-frame the write bank is published to the host as a stable read bank, so the host never reads a half-written frame. Sits between the simple_lsd instances and pspl_comm, and generalises the single-channel LSD output buffer to N channels with frame-safe ping-pong, overflow and drop reporting.

Parameters:
NUM_CH, 2, number of camera channels
H_BITW, 10, horizontal coordinate width
V_BITW, 9, vertical coordinate width
DEPTH, 256, segments per bank per channel (power of two)
CNT_W, 16, width of the per-channel drop counter
MIN_LEN, 8, minimum segment length in pixels; used only when LSD_BUF_MIN_LEN_EN is defined

Ports:
clock  in  1  system clock (clk_12m domain)
n_rst  in  1  asynchronous active-low reset
in_flag  in  NUM_CH  per-channel one-cycle end-of-frame pulse
in_valid  in  NUM_CH  per-channel segment-valid strobe
in_start_v  in  NUM_CH*V_BITW  packed start v; channel c at [c*V_BITW +: V_BITW]
in_start_h  in  NUM_CH*H_BITW  packed start h
in_end_v  in  NUM_CH*V_BITW  packed end v
in_end_h  in  NUM_CH*H_BITW  packed end h
in_rd_en  in  1  read strobe
in_rd_ch  in  clog2(NUM_CH) (min 1)  channel to read
in_rd_addr  in  32  segment index within the published frame
in_rd_done  in  NUM_CH  host release pulse, one bit per channel
out_ready  out  NUM_CH  published frame available
out_line_num  out  NUM_CH*32  segment count of the published frame
out_overflow  out  NUM_CH  published frame exceeded DEPTH
out_drop_cnt  out  NUM_CH*CNT_W  frames dropped because the host had not released
out_rd_valid  out  1  read data valid
out_start_v, out_end_v  out  V_BITW  read data
out_start_h, out_end_h  out  H_BITW  read data

Behaviour:
- Reset (async assert, sync deassert by the source): every output is 0. wbank=0 and wcnt=0 for all channels. RAM contents are don't-care.
- Storage: per channel 2*DEPTH entries of 2*(V_BITW+H_BITW) bits, inferred as simple dual-port BRAM. Address is {bank, index}.
- Write: when in_valid[c] is high and wcnt[c] < DEPTH, store the segment at {wbank[c], wcnt[c]} and increment wcnt[c].
- If in_valid[c] is high and wcnt[c] == DEPTH, discard the segment, set ovf_pend[c], and leave wcnt unchanged.
- End of frame (in_flag[c]):
  - in_valid[c] in the same cycle: the segment belongs to the ending frame and is counted before publication.
  - Release: if in_rd_done[c] is high, clear out_ready[c] first. Release takes priority over a coincident flag.
  - Publish: if out_ready[c] is 0 after release, then on the next cycle:
    - out_line_num[c] = final wcnt
    - out_overflow[c] = ovf_pend including this cycle
    - out_ready[c] = 1
    - rbank[c] = wbank[c], wbank[c] toggles, wcnt = 0, ovf_pend = 0
  - Drop: if the host still holds the read bank (out_ready[c] stays 1), the frame is discarded:
    - wcnt = 0, ovf_pend = 0, no bank toggle
    - published data unchanged
    - out_drop_cnt[c] increments, saturating at all ones
- in_rd_done[c] without in_flag[c]: clear out_ready[c] next cycle. out_line_num is held.
- Read: sample in_rd_en, in_rd_ch and in_rd_addr, and return data with out_rd_valid exactly one cycle later.
  - Source is the channel's {rbank, addr}.
  - If addr >= out_line_num[ch], or out_ready[ch] == 0, data is 0 and out_rd_valid is still 1.
  - in_rd_ch >= NUM_CH returns 0.
  - Back-to-back reads: one result per cycle.
- Channels are fully independent. Simultaneous flags on several channels are all handled in the same cycle.
- Reset mid-frame: everything clears. The first in_flag after reset publishes whatever segments were written since reset.

Optional Feature:
LSD_BUF_MIN_LEN_EN
- Defined: a segment is written only if |end_v-start_v| + |end_h-start_h| >= MIN_LEN.
  - Rejected segments do not increment wcnt and do not set ovf_pend.
  - Adds one register stage on the write path, with in_flag delayed by the same amount so ordering is preserved.
- Undefined: every valid segment is written. No length logic, zero-latency write path as above.

Test Plan:
- Ch0 writes 5 segments, then in_flag[0] -> next cycle out_ready=01, out_line_num[0]=5. Read addr 0..4 returns them in order, 1-cycle latency. Addr 5 -> 0 with out_rd_valid=1.
- Ch0 frame published and not released; second frame of 3 segments plus flag -> out_drop_cnt[0]=1, out_line_num[0] still 5, reads unchanged. Pulse in_rd_done[0] -> out_ready[0]=0. Next frame publishes normally.
- DEPTH+4 valid writes on ch1 then flag -> out_line_num[1]=DEPTH, out_overflow[1]=1. Next frame of 2 segments after release -> out_overflow[1]=0.
- in_valid, in_flag and in_rd_done on ch0 in the same cycle while out_ready[0]=1 -> segment counted, new frame published (no drop), bank toggled.
- Both channels flag in the same cycle with 7 and 9 segments -> out_line_num = 7 and 9. Reads with in_rd_ch alternating 0/1 each cycle return the correct per-channel data.
- Assert n_rst low mid-frame and mid-read -> all outputs 0 immediately. After release, 2 writes plus flag -> out_line_num=2. With LSD_BUF_MIN_LEN_EN and MIN_LEN=8: segments of length 3 and 12 -> count 1.

Source files
------------

// File: rtl/lsd_line_buffer_mc.sv
// Multi-channel ping-pong line-segment buffer between simple_lsd writers and a shared host read port.
// Optional minimum-length filter: define LSD_BUF_MIN_LEN_EN (adds one register stage on the write path).
module lsd_line_buffer_mc #(
    parameter int NUM_CH  = 2,
    parameter int H_BITW  = 10,
    parameter int V_BITW  = 9,
    parameter int DEPTH   = 256,
    parameter int CNT_W   = 16,
    parameter int MIN_LEN = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clock,
    input  logic                       n_rst,
    input  logic [NUM_CH-1:0]          in_flag,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*V_BITW-1:0]   in_start_v,
    input  logic [NUM_CH*H_BITW-1:0]   in_start_h,
    input  logic [NUM_CH*V_BITW-1:0]   in_end_v,
    input  logic [NUM_CH*H_BITW-1:0]   in_end_h,
    input  logic                       in_rd_en,
    input  logic [CH_W-1:0]            in_rd_ch,
    input  logic [31:0]                in_rd_addr,
    input  logic [NUM_CH-1:0]          in_rd_done,
    output logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*32-1:0]       out_line_num,
    output logic [NUM_CH-1:0]          out_overflow,
    output logic [NUM_CH*CNT_W-1:0]    out_drop_cnt,
    output logic                       out_rd_valid,
    output logic [V_BITW-1:0]          out_start_v,
    output logic [H_BITW-1:0]          out_start_h,
    output logic [V_BITW-1:0]          out_end_v,
    output logic [H_BITW-1:0]          out_end_h
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 2 * (V_BITW + H_BITW);

    logic [NUM_CH*DW-1:0] rd_flat;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DW-1:0] seg_in;
        logic [DW-1:0] eff_seg;
        logic          eff_valid;
        logic          eff_flag;

        assign seg_in = {in_start_v[c*V_BITW +: V_BITW], in_start_h[c*H_BITW +: H_BITW],
                         in_end_v[c*V_BITW +: V_BITW], in_end_h[c*H_BITW +: H_BITW]};

`ifdef LSD_BUF_MIN_LEN_EN
        localparam int LW = ((V_BITW > H_BITW) ? V_BITW : H_BITW) + 2;
        logic [LW-1:0] dv;
        logic [LW-1:0] dh;
        logic [LW-1:0] len;
        logic          ok_q;
        logic          flag_q;
        logic [DW-1:0] seg_q;

        always_comb begin
            dv = '0;
            dh = '0;
            if (in_end_v[c*V_BITW +: V_BITW] >= in_start_v[c*V_BITW +: V_BITW])
                dv = LW'(in_end_v[c*V_BITW +: V_BITW]) - LW'(in_start_v[c*V_BITW +: V_BITW]);
            else
                dv = LW'(in_start_v[c*V_BITW +: V_BITW]) - LW'(in_end_v[c*V_BITW +: V_BITW]);
            if (in_end_h[c*H_BITW +: H_BITW] >= in_start_h[c*H_BITW +: H_BITW])
                dh = LW'(in_end_h[c*H_BITW +: H_BITW]) - LW'(in_start_h[c*H_BITW +: H_BITW]);
            else
                dh = LW'(in_start_h[c*H_BITW +: H_BITW]) - LW'(in_end_h[c*H_BITW +: H_BITW]);
            len = dv + dh;
        end

        // Flag travels with the data so a segment never lands after its own end-of-frame.
        always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
                ok_q   <= 1'b0;
                flag_q <= 1'b0;
                seg_q  <= '0;
            end else begin
                ok_q   <= in_valid[c] && (len >= LW'(MIN_LEN));
                flag_q <= in_flag[c];
                seg_q  <= seg_in;
            end
        end

        assign eff_valid = ok_q;
        assign eff_flag  = flag_q;
        assign eff_seg   = seg_q;
`else
        assign eff_valid = in_valid[c];
        assign eff_flag  = in_flag[c];
        assign eff_seg   = seg_in;
`endif

        logic [DW-1:0]    mem [2*DEPTH];
        logic [DW-1:0]    rd_q;
        logic             wbank;
        logic             rbank;
        logic [AW:0]      wcnt;
        logic             ovf_pend;
        logic             ready;
        logic [31:0]      line_num;
        logic             overflow;
        logic [CNT_W-1:0] drop_cnt;

        logic        wr_ok;
        logic        ovf_now;
        logic        ready_after;
        logic        final_ovf;
        logic [AW:0] final_cnt;

        always_comb begin
            wr_ok       = eff_valid && !wcnt[AW];
            ovf_now     = eff_valid && wcnt[AW];
            final_cnt   = wcnt + (AW+1)'(wr_ok);
            final_ovf   = ovf_pend | ovf_now;
            ready_after = ready & ~in_rd_done[c];
        end

        always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
                wbank    <= 1'b0;
                rbank    <= 1'b0;
                wcnt     <= '0;
                ovf_pend <= 1'b0;
                ready    <= 1'b0;
                line_num <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (eff_flag) begin
                wcnt     <= '0;
                ovf_pend <= 1'b0;
                if (!ready_after) begin
                    line_num <= 32'(final_cnt);
                    overflow <= final_ovf;
                    ready    <= 1'b1;
                    rbank    <= wbank;
                    wbank    <= ~wbank;
                end else if (!(&drop_cnt)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else begin
                wcnt     <= final_cnt;
                ovf_pend <= final_ovf;
                if (in_rd_done[c])
                    ready <= 1'b0;
            end
        end

        // RAM: one write port, one read port, no reset so it maps onto block RAM.
        always_ff @(posedge clock) begin
            if (wr_ok)
                mem[{wbank, wcnt[AW-1:0]}] <= eff_seg;
            rd_q <= mem[{rbank, in_rd_addr[AW-1:0]}];
        end

        assign rd_flat[c*DW +: DW]          = rd_q;
        assign out_ready[c]                 = ready;
        assign out_line_num[c*32 +: 32]     = line_num;
        assign out_overflow[c]              = overflow;
        assign out_drop_cnt[c*CNT_W +: CNT_W] = drop_cnt;
    end

    logic            rd_ok;
    logic            rd_ok_q;
    logic [CH_W-1:0] rd_ch_q;
    logic [DW-1:0]   rd_sel;

    always_comb begin
        rd_ok = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(in_rd_ch) == c && out_ready[c] && (in_rd_addr < out_line_num[c*32 +: 32]))
                rd_ok = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_rd_valid <= 1'b0;
            rd_ok_q      <= 1'b0;
            rd_ch_q      <= '0;
        end else begin
            out_rd_valid <= in_rd_en;
            rd_ok_q      <= in_rd_en && rd_ok;
            rd_ch_q      <= in_rd_ch;
        end
    end

    // Out-of-range and unpublished reads still complete, just with zero data.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ok_q && int'(rd_ch_q) == c)
                rd_sel = rd_flat[c*DW +: DW];
        end
    end

    assign {out_start_v, out_start_h, out_end_v, out_end_h} = rd_sel;

endmodule

// File: tb/tb_lsd_line_buffer_mc.sv
// Directed self-checking bench for lsd_line_buffer_mc (default build, LSD_BUF_MIN_LEN_EN undefined).
module tb_lsd_line_buffer_mc;

    localparam int NUM_CH = 2;
    localparam int H_BITW = 10;
    localparam int V_BITW = 9;
    localparam int DEPTH  = 256;
    localparam int CNT_W  = 16;

    logic                     clock;
    logic                     n_rst;
    logic [NUM_CH-1:0]        in_flag;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*V_BITW-1:0] in_start_v;
    logic [NUM_CH*H_BITW-1:0] in_start_h;
    logic [NUM_CH*V_BITW-1:0] in_end_v;
    logic [NUM_CH*H_BITW-1:0] in_end_h;
    logic                     in_rd_en;
    logic [0:0]               in_rd_ch;
    logic [31:0]              in_rd_addr;
    logic [NUM_CH-1:0]        in_rd_done;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*32-1:0]     out_line_num;
    logic [NUM_CH-1:0]        out_overflow;
    logic [NUM_CH*CNT_W-1:0]  out_drop_cnt;
    logic                     out_rd_valid;
    logic [V_BITW-1:0]        out_start_v;
    logic [H_BITW-1:0]        out_start_h;
    logic [V_BITW-1:0]        out_end_v;
    logic [H_BITW-1:0]        out_end_h;

    int checks   = 0;
    int failures = 0;

    lsd_line_buffer_mc #(
        .NUM_CH(NUM_CH), .H_BITW(H_BITW), .V_BITW(V_BITW),
        .DEPTH(DEPTH), .CNT_W(CNT_W), .MIN_LEN(8)
    ) dut (
        .clock(clock), .n_rst(n_rst),
        .in_flag(in_flag), .in_valid(in_valid),
        .in_start_v(in_start_v), .in_start_h(in_start_h),
        .in_end_v(in_end_v), .in_end_h(in_end_h),
        .in_rd_en(in_rd_en), .in_rd_ch(in_rd_ch), .in_rd_addr(in_rd_addr),
        .in_rd_done(in_rd_done),
        .out_ready(out_ready), .out_line_num(out_line_num),
        .out_overflow(out_overflow), .out_drop_cnt(out_drop_cnt),
        .out_rd_valid(out_rd_valid),
        .out_start_v(out_start_v), .out_start_h(out_start_h),
        .out_end_v(out_end_v), .out_end_h(out_end_h)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Distinct, reproducible segment per (frame, channel, index).
    function automatic logic [37:0] seg(input int f, input int c, input int i);
        logic [8:0] sv;
        logic [9:0] sh;
        logic [8:0] ev;
        logic [9:0] eh;
        sv = 9'((f * 37 + c * 101 + i) % 512);
        sh = 10'((f * 53 + c * 11 + i * 3) % 1024);
        ev = 9'((f * 7 + i * 5 + 17) % 512);
        eh = 10'((f * 29 + c * 13 + i + 300) % 1024);
        return {sv, sh, ev, eh};
    endfunction

    task automatic put_seg(input int c, input logic [37:0] s);
        in_start_v[c*V_BITW +: V_BITW] = s[37:29];
        in_start_h[c*H_BITW +: H_BITW] = s[28:19];
        in_end_v[c*V_BITW +: V_BITW]   = s[18:10];
        in_end_h[c*H_BITW +: H_BITW]   = s[9:0];
    endtask

    task automatic wr_frame(input int c, input int f, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid[c] = 1'b1;
            put_seg(c, seg(f, c, i));
            tick();
        end
        in_valid[c] = 1'b0;
    endtask

    task automatic pulse_flag(input logic [1:0] m);
        in_flag = m;
        tick();
        in_flag = '0;
    endtask

    task automatic pulse_done(input logic [1:0] m);
        in_rd_done = m;
        tick();
        in_rd_done = '0;
    endtask

    // Leaves in_rd_en high so consecutive calls form a back-to-back burst.
    task automatic rd(input int c, input int a, input logic [37:0] exp, input string tag);
        in_rd_en   = 1'b1;
        in_rd_ch   = 1'(c);
        in_rd_addr = 32'(a);
        tick();
        chk({tag, "_vld"}, 64'(out_rd_valid), 64'd1);
        chk(tag, 64'({out_start_v, out_start_h, out_end_v, out_end_h}), 64'(exp));
    endtask

    task automatic rd_stop();
        in_rd_en = 1'b0;
        tick();
        chk("rd_valid_idle", 64'(out_rd_valid), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(out_ready), 64'd0);
        chk({tag, "_line"},  64'(out_line_num), 64'd0);
        chk({tag, "_ovf"},   64'(out_overflow), 64'd0);
        chk({tag, "_drop"},  64'(out_drop_cnt), 64'd0);
        chk({tag, "_rdv"},   64'(out_rd_valid), 64'd0);
        chk({tag, "_data"},  64'({out_start_v, out_start_h, out_end_v, out_end_h}), 64'd0);
    endtask

    initial begin
        n_rst      = 1'b0;
        in_flag    = '0;
        in_valid   = '0;
        in_start_v = '0;
        in_start_h = '0;
        in_end_v   = '0;
        in_end_h   = '0;
        in_rd_en   = 1'b0;
        in_rd_ch   = '0;
        in_rd_addr = '0;
        in_rd_done = '0;
        tick();
        tick();
        chk_all_zero("reset");
        n_rst = 1'b1;
        tick();

        // Basic frame on ch0 and in-order reads with one out-of-range address.
        wr_frame(0, 1, 5);
        pulse_flag(2'b01);
        chk("f1_ready", 64'(out_ready), 64'b01);
        chk("f1_line0", 64'(out_line_num[31:0]), 64'd5);
        chk("f1_ovf",   64'(out_overflow), 64'd0);
        for (int a = 0; a < 5; a++)
            rd(0, a, seg(1, 0, a), $sformatf("f1_rd%0d", a));
        rd(0, 5, 38'd0, "f1_rd_oob");
        rd_stop();

        // Unreleased frame gets dropped; published data stays.
        wr_frame(0, 2, 3);
        pulse_flag(2'b01);
        chk("drop_cnt0",  64'(out_drop_cnt[15:0]), 64'd1);
        chk("drop_line0", 64'(out_line_num[31:0]), 64'd5);
        chk("drop_ready", 64'(out_ready), 64'b01);
        rd(0, 0, seg(1, 0, 0), "drop_rd0");
        rd(0, 2, seg(1, 0, 2), "drop_rd2");
        rd_stop();
        pulse_done(2'b01);
        chk("rel_ready", 64'(out_ready), 64'b00);
        chk("rel_line0", 64'(out_line_num[31:0]), 64'd5);
        rd(0, 0, 38'd0, "rel_rd_unready");
        rd_stop();
        wr_frame(0, 3, 4);
        pulse_flag(2'b01);
        chk("f3_ready", 64'(out_ready), 64'b01);
        chk("f3_line0", 64'(out_line_num[31:0]), 64'd4);
        rd(0, 3, seg(3, 0, 3), "f3_rd3");
        rd(0, 0, seg(3, 0, 0), "f3_rd0");
        rd_stop();

        // Overflow on ch1.
        wr_frame(1, 4, DEPTH + 4);
        pulse_flag(2'b10);
        chk("ovf_line1",  64'(out_line_num[63:32]), 64'(DEPTH));
        chk("ovf_flag",   64'(out_overflow), 64'b10);
        chk("ovf_ready",  64'(out_ready), 64'b11);
        rd(1, DEPTH - 1, seg(4, 1, DEPTH - 1), "ovf_rd_last");
        rd(1, DEPTH, 38'd0, "ovf_rd_oob");
        rd(1, 0, seg(4, 1, 0), "ovf_rd0");
        rd_stop();
        pulse_done(2'b10);
        wr_frame(1, 5, 2);
        pulse_flag(2'b10);
        chk("f5_line1", 64'(out_line_num[63:32]), 64'd2);
        chk("f5_ovf",   64'(out_overflow), 64'b00);

        // Valid, flag and release together while ch0 is still held.
        wr_frame(0, 6, 2);
        in_valid[0]   = 1'b1;
        put_seg(0, seg(6, 0, 2));
        in_flag[0]    = 1'b1;
        in_rd_done[0] = 1'b1;
        tick();
        in_valid   = '0;
        in_flag    = '0;
        in_rd_done = '0;
        chk("co_ready", 64'(out_ready), 64'b11);
        chk("co_line0", 64'(out_line_num[31:0]), 64'd3);
        chk("co_drop0", 64'(out_drop_cnt[15:0]), 64'd1);
        rd(0, 2, seg(6, 0, 2), "co_rd2");
        rd(0, 0, seg(6, 0, 0), "co_rd0");
        rd_stop();

        // Both channels flag together; interleaved channel reads.
        pulse_done(2'b11);
        chk("both_rel", 64'(out_ready), 64'b00);
        for (int i = 0; i < 9; i++) begin
            in_valid = {1'b1, (i < 7) ? 1'b1 : 1'b0};
            put_seg(0, seg(7, 0, i));
            put_seg(1, seg(7, 1, i));
            tick();
        end
        in_valid = '0;
        pulse_flag(2'b11);
        chk("both_ready", 64'(out_ready), 64'b11);
        chk("both_line",  64'(out_line_num), {32'd9, 32'd7});
        for (int i = 0; i < 10; i++) begin
            int c;
            int a;
            int n;
            c = i % 2;
            a = i / 2 + ((c == 1) ? 5 : 3);
            n = (c == 1) ? 9 : 7;
            rd(c, a, (a < n) ? seg(7, c, a) : 38'd0, $sformatf("alt_ch%0d_a%0d", c, a));
        end
        rd_stop();

        // Reset in the middle of a frame and of a read.
        wr_frame(0, 9, 3);
        in_rd_en   = 1'b1;
        in_rd_ch   = 1'b1;
        in_rd_addr = 32'd0;
        tick();
        chk("pre_rst_rdv",  64'(out_rd_valid), 64'd1);
        chk("pre_rst_data", 64'({out_start_v, out_start_h, out_end_v, out_end_h}), 64'(seg(7, 1, 0)));
        #2;
        n_rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        in_rd_en = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        wr_frame(0, 10, 2);
        pulse_flag(2'b01);
        chk("post_ready", 64'(out_ready), 64'b01);
        chk("post_line",  64'(out_line_num), {32'd0, 32'd2});
        chk("post_drop",  64'(out_drop_cnt), 64'd0);
        rd(0, 1, seg(10, 0, 1), "post_rd1");
        rd(0, 2, 38'd0, "post_rd_oob");
        rd_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
